// File: rtl/psa_reduce_seq.sv
// Multi-cycle reduction of two packed 4x4-bit signed operands into one 16-bit sum plus lane-overflow flag.
// Define PSA_RED_FAST_EN to process two lanes per cycle (2-cycle latency instead of 4).
module psa_reduce_seq #(
   parameter int LANES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] A,
   input  logic [15:0] B,
   output logic        busy,
   output logic        done,
   output logic [15:0] Sum,
   output logic        Ovfl,
   output logic [1:0]  state_dbg_o
);

`ifdef PSA_RED_FAST_EN
   localparam int STEP = 2;
`else
   localparam int STEP = 1;
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Handshake: start is accepted only in IDLE/DONE; busy and done are
   // decoded from the state so they can never be high together. Sum/Ovfl
   // are valid only while done is high and hold the last result otherwise.
   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;
   logic [15:0] acc_q, acc_d;
   logic        ovf_q, ovf_d;
   logic [15:0] sum_q, sum_d;
   logic        ovfl_q, ovfl_d;

   function automatic logic [15:0] lane_val(input logic [15:0] a, input logic [15:0] b,
                                             input logic [1:0] l);
      logic [3:0] an, bn;
      an = a[{l, 2'b00} +: 4];
      bn = b[{l, 2'b00} +: 4];
      return {{12{an[3]}}, an} + {{12{bn[3]}}, bn};
   endfunction

   function automatic logic lane_ovf(input logic [15:0] a, input logic [15:0] b,
                                     input logic [1:0] l);
      logic [3:0] an, bn, s;
      an = a[{l, 2'b00} +: 4];
      bn = b[{l, 2'b00} +: 4];
      s  = an + bn;
      return (an[3] == bn[3]) && (s[3] != an[3]);
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      sum_d   = sum_q;
      ovfl_d  = ovfl_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_d     = A;
               b_d     = B;
               acc_d   = '0;
               ovf_d   = 1'b0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            for (int k = 0; k < STEP; k++) begin
               acc_d = acc_d + lane_val(a_q, b_q, cnt_q + 2'(k));
               ovf_d = ovf_d | lane_ovf(a_q, b_q, cnt_q + 2'(k));
            end
            cnt_d = cnt_q + 2'(STEP);
            // Result registers only move on the final lane step.
            if (cnt_q == 2'(LANES - STEP)) begin
               sum_d   = acc_d;
               ovfl_d  = ovf_d;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         sum_q   <= '0;
         ovfl_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
         sum_q   <= sum_d;
         ovfl_q  <= ovfl_d;
      end
   end

   assign busy        = (state_q == RUN);
   assign done        = (state_q == DONE);
   assign Sum         = sum_q;
   assign Ovfl        = ovfl_q;
   assign state_dbg_o = state_q;

endmodule

// File: tb/tb_psa_reduce_seq.sv
// Directed bench for psa_reduce_seq: vector table plus hand-written restart/reset sequences.
module tb_psa_reduce_seq;

`ifdef PSA_RED_FAST_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 4;
`endif

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] A, B;
   logic        busy, done, Ovfl;
   logic [15:0] Sum;
   logic [1:0]  state_dbg;

   int passed = 0;
   int total  = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] exp_sum;
      logic        exp_ovf;
   } vec_t;

   vec_t vecs[10];

   psa_reduce_seq #(.LANES(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .A           (A),
      .B           (B),
      .busy        (busy),
      .done        (done),
      .Sum         (Sum),
      .Ovfl        (Ovfl),
      .state_dbg_o (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
   endtask

   // Drives a start and checks the E0 edge result.
   task automatic drive_start(input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      start = 1'b1;
      A = a;
      B = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("e0_busy", 16'(busy), 16'd1);
      check("e0_done", 16'(done), 16'd0);
   endtask

   // Runs E1..E_LAT scrambling A/B; optionally pulses start before edge pulse_at.
   task automatic finish_op(input logic [15:0] exp_sum, input logic exp_ovf, input int pulse_at);
      for (int e = 1; e <= LAT; e++) begin
         @(negedge clk);
         A = 16'($urandom);
         B = 16'($urandom);
         start = (e == pulse_at);
         @(posedge clk);
         #1;
         start = 1'b0;
         if (e < LAT) begin
            check("run_busy", 16'(busy), 16'd1);
            check("run_done", 16'(done), 16'd0);
         end
      end
      check("end_busy", 16'(busy), 16'd0);
      check("end_done", 16'(done), 16'd1);
      check("end_sum", Sum, exp_sum);
      check("end_ovfl", 16'(Ovfl), 16'(exp_ovf));
   endtask

   initial begin
      vecs[0] = '{16'h1234, 16'h0000, 16'h000A, 1'b0};
      vecs[1] = '{16'hFFFF, 16'hFFFF, 16'hFFF8, 1'b0};
      vecs[2] = '{16'h7777, 16'h7777, 16'h0038, 1'b1};
      vecs[3] = '{16'h8888, 16'h8888, 16'hFFC0, 1'b1};
      vecs[4] = '{16'h1111, 16'h1111, 16'h0008, 1'b0};
      vecs[5] = '{16'h0001, 16'h0001, 16'h0002, 1'b0};
      vecs[6] = '{16'h7000, 16'h1000, 16'h0008, 1'b1};
      vecs[7] = '{16'h0F00, 16'h0100, 16'h0000, 1'b0};
      vecs[8] = '{16'h8000, 16'h0000, 16'hFFF8, 1'b0};
      vecs[9] = '{16'h9000, 16'hF000, 16'hFFF8, 1'b0};

      rst_n = 1'b0;
      start = 1'b0;
      A = '0;
      B = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 16'(busy), 16'd0);
      check("rst_done", 16'(done), 16'd0);
      check("rst_sum", Sum, 16'h0000);
      check("rst_ovfl", 16'(Ovfl), 16'd0);
      check("rst_state", 16'(state_dbg), 16'd0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         drive_start(vecs[i].a, vecs[i].b);
         finish_op(vecs[i].exp_sum, vecs[i].exp_ovf, 0);
      end

      // start during RUN is ignored
      drive_start(16'h1111, 16'h1111);
      finish_op(16'h0008, 1'b0, LAT / 2);
      repeat (2) @(posedge clk);
      #1;
      check("hold_done", 16'(done), 16'd1);
      check("hold_sum", Sum, 16'h0008);

      // start from DONE: done drops, old result stays until completion
      drive_start(16'h7777, 16'h7777);
      check("stale_sum", Sum, 16'h0008);
      check("stale_ovfl", 16'(Ovfl), 16'd0);
      finish_op(16'h0038, 1'b1, 0);

      // asynchronous reset in the middle of a run
      drive_start(16'h8888, 16'h8888);
      repeat (LAT / 2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 16'(busy), 16'd0);
      check("mid_rst_done", 16'(done), 16'd0);
      check("mid_rst_sum", Sum, 16'h0000);
      check("mid_rst_ovfl", 16'(Ovfl), 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      drive_start(16'h0001, 16'h0001);
      finish_op(16'h0002, 1'b0, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
